instr_fetch_unit: RTL and testbench

//  Fetch stage between the PC and the decoder. Holds the program counter and

---
 rtl/instr_fetch_unit_if.sv | 37 +++
 rtl/instr_fetch_unit.sv | 80 ++++++++
 tb/tb_instr_fetch_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, branch redirect
// and the valid/ready handshake towards decode.
interface instr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus8;

  modport master (
    output imem_addr,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus8
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus8
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, combinational imem access and a small
// prefetch FIFO presented to decode; redirects flush everything.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  instr_fetch_unit_if.master   bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t          fifo [DEPTH];
  entry_t          head;
  logic [31:0]     pc;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            valid;
  logic            push;
  logic            pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid = (count != '0);
  assign pop   = valid & bus.out_ready;
  assign push  = ~bus.redirect_valid
               & ((count < CW'(DEPTH)) | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_valid) begin
      pc     <= {bus.redirect_target[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= '{instr: bus.imem_rd, pc: pc};
    end
  end

  assign head             = fifo[rd_ptr];
  assign bus.imem_addr    = pc;
  assign bus.out_valid    = valid;
  assign bus.out_instr    = head.instr;
  assign bus.out_pc       = head.pc;
  assign bus.out_pc_plus8 = head.pc + 32'd8;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked
// every cycle, plus directed literal checks.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hE3A0_9000;
      32'h4:   return 32'hE3A0_00C8;
      32'h8:   return 32'hE3A0_2014;
      default: return ~a ^ 32'h1234_5678;
    endcase
  endfunction

  assign bus.imem_rd = mem_word(bus.imem_addr);

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue of {instr, pc}
  logic [63:0] mq[$];
  logic [31:0] mpc = RESET_PC;

  always @(posedge clk or negedge reset_n) begin
    int  sz;
    bit  mpop;
    if (!reset_n) begin
      mq.delete();
      mpc = RESET_PC;
    end else begin
      sz   = mq.size();
      mpop = (sz != 0) && bus.out_ready;
      if (bus.redirect_valid) begin
        mq.delete();
        mpc = bus.redirect_target & 32'hFFFF_FFFC;
      end else begin
        if (mpop) void'(mq.pop_front());
        if (sz < DEPTH || mpop) begin
          mq.push_back({mem_word(mpc), mpc});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_valid", {31'd0, bus.out_valid},
          {31'd0, mq.size() != 0});
    check("model_addr", bus.imem_addr, mpc);
    if (mq.size() != 0) begin
      check("model_instr", bus.out_instr, mq[0][63:32]);
      check("model_pc", bus.out_pc, mq[0][31:0]);
      check("model_pc8", bus.out_pc_plus8,
            mq[0][31:0] + 32'd8);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] t);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = t;
    step();
    bus.redirect_valid  = 1'b0;
  endtask

  initial begin
    reset_n             = 1'b0;
    bus.out_ready       = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;

    // 1: straight-line fetch after reset
    step();
    step();
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    reset_n = 1'b1;
    step();
    check("t1_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t1_pc0", bus.out_pc, 32'h0);
    check("t1_in0", bus.out_instr, 32'hE3A0_9000);
    check("t1_p80", bus.out_pc_plus8, 32'h8);
    step();
    check("t1_pc1", bus.out_pc, 32'h4);
    check("t1_in1", bus.out_instr, 32'hE3A0_00C8);
    check("t1_p81", bus.out_pc_plus8, 32'hC);
    step();
    check("t1_pc2", bus.out_pc, 32'h8);
    check("t1_in2", bus.out_instr, 32'hE3A0_2014);
    check("t1_p82", bus.out_pc_plus8, 32'h10);

    // 2: decode stalled, FIFO saturates
    reset_n = 1'b0;
    step();
    bus.out_ready = 1'b0;
    reset_n = 1'b1;
    repeat (5) step();
    check("t2_addr", bus.imem_addr, 32'h8);
    check("t2_pc0", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    step();
    check("t2_pc1", bus.out_pc, 32'h4);
    step();
    check("t2_pc2", bus.out_pc, 32'h8);

    // 3: redirect while full
    bus.out_ready = 1'b0;
    step();
    step();
    redir(32'h0000_0013);
    check("t3_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t3_addr", bus.imem_addr, 32'h10);
    step();
    check("t3_pc", bus.out_pc, 32'h10);

    // 4: redirect with pop, then back-to-back redirects
    step();
    bus.out_ready = 1'b1;
    redir(32'h0000_0100);
    check("t4_valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    check("t4_pc", bus.out_pc, 32'h100);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h200;
    step();
    redir(32'h300);
    step();
    check("t4_b2b0", bus.out_pc, 32'h300);
    step();
    check("t4_b2b1", bus.out_pc, 32'h304);

    // 5: PC wraps at top of address space
    redir(32'hFFFF_FFFC);
    step();
    check("t5_pc0", bus.out_pc, 32'hFFFF_FFFC);
    check("t5_p80", bus.out_pc_plus8, 32'h4);
    step();
    check("t5_pc1", bus.out_pc, 32'h0);
    check("t5_p81", bus.out_pc_plus8, 32'h8);

    // 6: async reset between edges with a full FIFO
    bus.out_ready = 1'b0;
    step();
    step();
    check("t6_pre", {31'd0, bus.out_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t6_addr", bus.imem_addr, RESET_PC);
    #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("t6_pc", bus.out_pc, RESET_PC);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
